// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Purpose  : Shared types and constants for the serial magnitude comparator:
//             FSM state encoding, internal 2-bit result code, and a helper
//             for sizing the digit counter.
//  Revision : 1.0  initial release
// ============================================================================
package cmp_pkg;

    // Two-state controller: waiting for a request, or walking the digits.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    // Internal result code, decoded to LT/EQ/GT at the top level.
    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_LT = 2'b01;
    localparam logic [1:0] RES_GT = 2'b10;

    // Digit counter width: $clog2 of the digit count, never below one bit.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/serial_mag_comparator_digit_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : digit_cmp
//  Purpose  : Combinational unsigned magnitude compare of one DIGIT-bit
//             digit pair. Optionally flips the digit MSB of both operands so
//             that the leading digit of a two's-complement value orders
//             correctly under an unsigned compare.
//  Revision : 1.0  initial release
// ============================================================================
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             invert_msb,
    output logic             lt,
    output logic             gt
);

    localparam logic [DIGIT-1:0] C_MSB_ONE = DIGIT'(1) << (DIGIT - 1);

    logic [DIGIT-1:0] w_mask;
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;

    // Bias the sign bit (if requested) and compare the digits as unsigned.
    always_comb begin
        w_mask = invert_msb ? C_MSB_ONE : '0;
        w_a    = a_dig ^ w_mask;
        w_b    = b_dig ^ w_mask;
        lt     = (w_a < w_b);
        gt     = (w_a > w_b);
    end

endmodule : digit_cmp
`default_nettype wire

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mag_comparator
//  Purpose  : Digit-serial, MSB-first magnitude comparator with
//             start/busy/done handshake. Compares DIGIT bits per clock,
//             unsigned or two's-complement, and stops at the first
//             differing digit.
//  Revision : 1.0  initial release
// ============================================================================
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);

    localparam int              NDIG     = WIDTH / DIGIT;
    localparam int              CW       = cnt_width(NDIG);
    localparam logic [CW-1:0]   LAST_CNT = CW'(NDIG - 1);

    // Reject illegal geometries at elaboration time.
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_mag_comparator: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             sm_q,    sm_d;
    logic             done_q,  done_d;
    logic [1:0]       res_q,   res_d;
    logic             vld_q,   vld_d;

    logic             w_lt;
    logic             w_gt;
    logic             w_invert;

    // The operand registers shift left one digit per equal compare, so the
    // digit under test always sits in the top DIGIT bits. Only the very
    // first digit carries the sign bit.
    assign w_invert = sm_q && (cnt_q == '0);

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a_dig      (a_q[WIDTH-1 -: DIGIT]),
        .b_dig      (b_q[WIDTH-1 -: DIGIT]),
        .invert_msb (w_invert),
        .lt         (w_lt),
        .gt         (w_gt)
    );

    // State, counter, operand and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= RES_EQ;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            done_q  <= done_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state logic: accept in IDLE, one digit per edge in CMP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        done_d  = 1'b0;
        res_d   = res_q;
        vld_d   = vld_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CMP;
                    cnt_d   = '0;
                    a_d     = A;
                    b_d     = B;
                    sm_d    = signed_mode;
                    res_d   = RES_EQ;
                    vld_d   = 1'b0;
                end
            end
            ST_CMP: begin
                if (w_lt || w_gt) begin
                    state_d = ST_IDLE;
                    res_d   = w_lt ? RES_LT : RES_GT;
                    vld_d   = 1'b1;
                    done_d  = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    res_d   = RES_EQ;
                    vld_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    a_d     = a_q << DIGIT;
                    b_d     = b_q << DIGIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The result code is only presented once a compare has completed.
    assign busy = (state_q == ST_CMP);
    assign done = done_q;
    assign LT   = vld_q && (res_q == RES_LT);
    assign EQ   = vld_q && (res_q == RES_EQ);
    assign GT   = vld_q && (res_q == RES_GT);

endmodule : serial_mag_comparator
`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_mag_comparator
//  Purpose  : Scoreboard bench for serial_mag_comparator. A 16/4 instance
//             runs directed vectors; a 4/1 instance runs every operand pair
//             in both modes against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_mag_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic lt;
        logic eq;
        logic gt;
        int   lat;
        int   acc;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    exp_t e16;
    exp_t e4;

    // 16-bit, 4-bit digit instance
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        sm16 = 1'b0;
    logic        busy16, done16, lt16, eq16, gt16;

    serial_mag_comparator #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk (clk), .rst (rst), .start (start16), .A (a16), .B (b16),
        .signed_mode (sm16), .busy (busy16), .done (done16),
        .LT (lt16), .EQ (eq16), .GT (gt16)
    );

    // 4-bit, 1-bit digit instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       sm4 = 1'b0;
    logic       busy4, done4, lt4, eq4, gt4;

    serial_mag_comparator #(.WIDTH(4), .DIGIT(1)) u_dut4 (
        .clk (clk), .rst (rst), .start (start4), .A (a4), .B (b4),
        .signed_mode (sm4), .busy (busy4), .done (done4),
        .LT (lt4), .EQ (eq4), .GT (gt4)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the 16-bit instance.
    int   bc16 = 0;
    logic pd16 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            bc16 = 0;
        end else begin
            if (busy16) begin
                bc16++;
                chk("results_clear_while_busy16", int'({lt16, eq16, gt16}), 0);
            end
            if (done16) begin
                chk("done_single_pulse16", int'(pd16), 0);
                chk("busy_low_at_done16", int'(busy16), 0);
                if (q16.size() == 0) begin
                    chk("unexpected_done16", 1, 0);
                end else begin
                    e16 = q16.pop_front();
                    chk("result16_lt_eq_gt", int'({lt16, eq16, gt16}), int'({e16.lt, e16.eq, e16.gt}));
                    chk("latency16", cyc - e16.acc, e16.lat);
                    chk("busy_cycles16", bc16, e16.lat);
                end
                bc16 = 0;
            end
        end
        pd16 = done16;
    end

    // Monitor for the 4-bit instance.
    int   bc4 = 0;
    logic pd4 = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            bc4 = 0;
        end else begin
            if (busy4) begin
                bc4++;
                chk("results_clear_while_busy4", int'({lt4, eq4, gt4}), 0);
            end
            if (done4) begin
                chk("done_single_pulse4", int'(pd4), 0);
                if (q4.size() == 0) begin
                    chk("unexpected_done4", 1, 0);
                end else begin
                    e4 = q4.pop_front();
                    chk("result4_lt_eq_gt", int'({lt4, eq4, gt4}), int'({e4.lt, e4.eq, e4.gt}));
                    chk("latency4", cyc - e4.acc, e4.lat);
                    chk("busy_cycles4", bc4, e4.lat);
                end
                bc4 = 0;
            end
        end
        pd4 = done4;
    end

    // Drive a request for one edge; called just after a rising edge.
    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic elt, input logic eeq, input logic egt,
                        input int lat, input bit push_exp);
        a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
        if (push_exp) q16.push_back(exp_t'{elt, eeq, egt, lat, cyc + 1});
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic wait16(input string nm);
        int n = 0;
        while (!done16 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_done_seen"}, int'(done16), 1);
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic elt, input logic eeq, input logic egt, input int lat);
        a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
        q4.push_back(exp_t'{elt, eeq, egt, lat, cyc + 1});
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic wait4();
        int n = 0;
        while (!done4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sweep4_done_seen", int'(done4), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] av, bv;
        logic       elt, eeq, egt;
        int         k;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy16", int'(busy16), 0);
        chk("reset_done16", int'(done16), 0);
        chk("reset_results16", int'({lt16, eq16, gt16}), 0);
        chk("reset_busy4", int'(busy4), 0);
        chk("reset_results4", int'({lt4, eq4, gt4}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Equal operands walk all four digits
        go16(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1);
        wait16("eq_1234");
        // MSB digit decides; unsigned vs signed
        go16(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        wait16("u_8000_7fff");
        go16(16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        wait16("s_8000_7fff");
        // -2 < -1, decided in the last digit
        go16(16'hFFFE, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b1);
        wait16("s_fffe_ffff");
        // Third digit differs
        go16(16'h0010, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        wait16("u_0010_0020");
        // Back-to-back: next start issued in the done cycle
        go16(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1);
        wait16("u_1235_1234");
        go16(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1);
        wait16("b2b_0001_0002");

        // Inputs changed and start pulsed while busy are ignored
        go16(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        a16 = 16'h0000; b16 = 16'hFFFF; sm16 = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        wait16("busy_ignore");
        @(posedge clk); #1;
        chk("busy_ignore_no_accept", int'(busy16), 0);

        // Reset after two CMP edges aborts the compare
        go16(16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy16), 0);
        chk("abort_results", int'({lt16, eq16, gt16}), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", int'(done16), 0);
        end
        go16(16'hABCD, 16'hABCC, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1);
        wait16("after_abort");
        @(posedge clk); #1;

        // Reset wins over a simultaneous start
        a16 = 16'h0005; b16 = 16'h0003; sm16 = 1'b0; start16 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start16 = 1'b0;
        chk("rst_start_busy", int'(busy16), 0);
        @(posedge clk); #1;
        chk("rst_start_busy_later", int'(busy16), 0);
        chk("rst_start_no_done", int'(done16), 0);

        // Exhaustive 4-bit sweep, one bit per cycle, both modes
        for (int sm = 0; sm < 2; sm++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    av = 4'(a);
                    bv = 4'(b);
                    if (sm != 0) begin
                        elt = ($signed(av) < $signed(bv));
                        egt = ($signed(av) > $signed(bv));
                    end else begin
                        elt = (av < bv);
                        egt = (av > bv);
                    end
                    eeq = (av == bv);
                    k = 4;
                    for (int i = 3; i >= 0; i--) begin
                        if (av[i] != bv[i] && k == 4 && i != 3 - (4 - k)) begin
                            k = k;
                        end
                    end
                    k = 4;
                    for (int i = 3; i >= 0; i--) begin
                        if (av[i] != bv[i]) begin
                            k = 4 - i;
                            break;
                        end
                    end
                    go4(av, bv, sm[0], elt, eeq, egt, k);
                    wait4();
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue16_drained", q16.size(), 0);
        chk("queue4_drained", q4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_mag_comparator
`default_nettype wire
